// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready stage that resolves MEM/WB bypassing
// at capture time and keeps saturating stall/flush performance counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [4:0]       in_rs1_idx,
    input  logic [4:0]       in_rs2_idx,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    input  logic [31:0]      in_imm,
    input  logic             in_use_imm,
    input  logic [2:0]       in_alu_op,
    input  logic [4:0]       in_rd_idx,
    input  logic             in_rd_we,
    input  logic             fwd_mem_valid,
    input  logic [4:0]       fwd_mem_rd,
    input  logic [31:0]      fwd_mem_data,
    input  logic             fwd_wb_valid,
    input  logic [4:0]       fwd_wb_rd,
    input  logic [31:0]      fwd_wb_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_rs2_val,
    output logic [4:0]       out_rd_idx,
    output logic             out_rd_we,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       OP_RSVD = 3'd7;

    logic             r_valid;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [2:0]       r_alu_op;
    logic [31:0]      r_pc;
    logic [31:0]      r_rs2_val;
    logic [4:0]       r_rd_idx;
    logic             r_rd_we;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_accept;
    logic [31:0]      w_rs1_fwd;
    logic [31:0]      w_rs2_fwd;

    // x0 is hardwired zero; the younger MEM result wins over WB.
    function automatic logic [31:0] f_fwd(
        input logic [4:0]  idx,
        input logic [31:0] rf_val,
        input logic        mem_v,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_d,
        input logic        wb_v,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_d
    );
        logic [31:0] res;
        if (idx == 5'd0) begin
            res = 32'd0;
        end else if (mem_v && (mem_rd == idx)) begin
            res = mem_d;
        end else if (wb_v && (wb_rd == idx)) begin
            res = wb_d;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    assign in_ready = (!r_valid || out_ready) && !flush && !rst;
    assign w_accept = in_valid && in_ready;

    // Bypass selection for both source operands
    always_comb begin
        w_rs1_fwd = f_fwd(in_rs1_idx, in_rs1_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        w_rs2_fwd = f_fwd(in_rs2_idx, in_rs2_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    end

    // Entry register: valid flag and payload capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_alu_a   <= 32'd0;
            r_alu_b   <= 32'd0;
            r_alu_op  <= 3'd0;
            r_pc      <= 32'd0;
            r_rs2_val <= 32'd0;
            r_rd_idx  <= 5'd0;
            r_rd_we   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_alu_a   <= w_rs1_fwd;
            r_alu_b   <= in_use_imm ? in_imm : w_rs2_fwd;
            r_alu_op  <= in_alu_op;
            r_pc      <= in_pc;
            r_rs2_val <= w_rs2_fwd;
            r_rd_idx  <= in_rd_idx;
            r_rd_we   <= in_rd_we && (in_rd_idx != 5'd0) && (in_alu_op != OP_RSVD);
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (r_valid && !out_ready && !flush && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (flush && r_valid && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign out_valid   = r_valid;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign out_pc      = r_pc;
    assign out_rs2_val = r_rs2_val;
    assign out_rd_idx  = r_rd_idx;
    assign out_rd_we   = r_rd_we;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a transaction-level model checked every cycle, plus directed
// vectors with literal expectations for forwarding, stalls, flush, immediates and saturation.
module tb_id_ex_stage;

    localparam int CNT_W = 16;
    localparam int CMAX  = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic        in_use_imm, in_rd_we;
    logic [2:0]  in_alu_op;
    logic        fwd_mem_valid, fwd_wb_valid;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        flush, out_ready, out_valid;
    logic [31:0] alu_a, alu_b, out_pc, out_rs2_val;
    logic [2:0]  alu_op;
    logic [4:0]  out_rd_idx;
    logic        out_rd_we;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_alu_op(in_alu_op), .in_rd_idx(in_rd_idx), .in_rd_we(in_rd_we),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .out_pc(out_pc), .out_rs2_val(out_rs2_val),
        .out_rd_idx(out_rd_idx), .out_rd_we(out_rd_we), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid;
    logic [31:0] m_a, m_b, m_pc, m_rs2;
    logic [2:0]  m_op;
    logic [4:0]  m_rd;
    bit          m_we;
    int          m_stall, m_flush;

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (fwd_mem_valid && fwd_mem_rd == idx) return fwd_mem_data;
        if (fwd_wb_valid && fwd_wb_rd == idx) return fwd_wb_data;
        return rf;
    endfunction

    always @(posedge clk) begin
        bit take, leave;
        if (rst) begin
            m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_pc = 32'd0; m_rs2 = 32'd0;
            m_op = 3'd0; m_rd = 5'd0; m_we = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_valid && !out_ready && !flush) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (m_valid && flush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            take  = in_valid && !flush && (!m_valid || out_ready);
            leave = m_valid && out_ready;
            if (take) begin
                m_a   = operand(in_rs1_idx, in_rs1_val);
                m_rs2 = operand(in_rs2_idx, in_rs2_val);
                m_b   = in_use_imm ? in_imm : m_rs2;
                m_op  = in_alu_op;
                m_pc  = in_pc;
                m_rd  = in_rd_idx;
                m_we  = in_rd_we && in_rd_idx != 5'd0 && in_alu_op != 3'd7;
            end
            m_valid = flush ? 1'b0 : (take ? 1'b1 : (leave ? 1'b0 : m_valid));
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("in_ready", {31'd0, in_ready},
                {31'd0, !rst && !flush && (!m_valid || out_ready)});
            chk("stall_cnt", {16'd0, stall_cnt}, m_stall[31:0]);
            chk("flush_cnt", {16'd0, flush_cnt}, m_flush[31:0]);
            if (m_valid) begin
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
                chk("alu_op", {29'd0, alu_op}, {29'd0, m_op});
                chk("out_pc", out_pc, m_pc);
                chk("out_rs2_val", out_rs2_val, m_rs2);
                chk("out_rd_idx", {27'd0, out_rd_idx}, {27'd0, m_rd});
                chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, m_we});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] v1,
                         input logic [4:0] r2, input logic [31:0] v2, input logic [2:0] op,
                         input logic [4:0] rd, input logic we);
        in_valid = 1'b1; in_pc = pc; in_rs1_idx = r1; in_rs1_val = v1;
        in_rs2_idx = r2; in_rs2_val = v2; in_alu_op = op; in_rd_idx = rd; in_rd_we = we;
        in_use_imm = 1'b0; in_imm = 32'd0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = 32'd0; in_rs1_idx = 5'd0; in_rs2_idx = 5'd0;
        in_rs1_val = 32'd0; in_rs2_val = 32'd0; in_imm = 32'd0; in_use_imm = 1'b0;
        in_alu_op = 3'd0; in_rd_idx = 5'd0; in_rd_we = 1'b0;
        fwd_mem_valid = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
        fwd_wb_valid = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0;
        flush = 1'b0; out_ready = 1'b1;
        tick();
        started = 1'b1;
        tick();
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        rst = 1'b0;

        // basic capture, 1-cycle latency
        offer(32'h100, 5'd3, 32'd5, 5'd4, 32'd7, 3'd0, 5'd1, 1'b1);
        tick();
        chk("basic out_valid", {31'd0, out_valid}, 32'd1);
        chk("basic alu_a", alu_a, 32'd5);
        chk("basic alu_b", alu_b, 32'd7);
        chk("basic alu_op", {29'd0, alu_op}, 32'd0);

        // forwarding priority
        offer(32'h104, 5'd5, 32'h11, 5'd0, 32'd0, 3'd1, 5'd2, 1'b1);
        fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAA;
        fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'hBB;
        tick();
        chk("fwd mem", alu_a, 32'hAA);
        fwd_mem_valid = 1'b0;
        tick();
        chk("fwd wb", alu_a, 32'hBB);
        in_rs1_idx = 5'd0; fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        tick();
        chk("fwd x0", alu_a, 32'd0);
        fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
        in_valid = 1'b0;
        tick();

        // back-pressure stall
        offer(32'h200, 5'd1, 32'd1, 5'd2, 32'd2, 3'd2, 5'd4, 1'b1);
        tick();
        out_ready = 1'b0; in_pc = 32'h300;
        #1;
        chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        repeat (4) tick();
        chk("stall hold pc", out_pc, 32'h200);
        chk("stall cnt4", {16'd0, stall_cnt}, 32'd4);
        out_ready = 1'b1;
        tick();
        chk("resume pc", out_pc, 32'h300);
        in_pc = 32'h304;
        tick();
        chk("b2b pc", out_pc, 32'h304);
        chk("b2b valid", {31'd0, out_valid}, 32'd1);

        // flush with held entry and offered instruction
        in_pc = 32'h400; flush = 1'b1;
        tick();
        chk("flush valid", {31'd0, out_valid}, 32'd0);
        chk("flush cnt", {16'd0, flush_cnt}, 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush no capture", {31'd0, out_valid}, 32'd0);

        // immediate operand and reserved opcode
        offer(32'h500, 5'd1, 32'd3, 5'd6, 32'd9, 3'd7, 5'd3, 1'b1);
        in_use_imm = 1'b1; in_imm = 32'hFFFFFFFC;
        tick();
        chk("imm alu_b", alu_b, 32'hFFFFFFFC);
        chk("imm rs2", out_rs2_val, 32'd9);
        chk("op7 we", {31'd0, out_rd_we}, 32'd0);
        chk("op7 op", {29'd0, alu_op}, 32'd7);
        offer(32'h504, 5'd1, 32'd3, 5'd6, 32'd9, 3'd0, 5'd0, 1'b1);
        tick();
        chk("rd0 we", {31'd0, out_rd_we}, 32'd0);
        offer(32'h508, 5'd1, 32'd3, 5'd6, 32'd9, 3'd5, 5'd2, 1'b1);
        tick();
        chk("mul we", {31'd0, out_rd_we}, 32'd1);
        in_valid = 1'b0;
        tick();

        // counter saturation then reset mid-stall
        rst = 1'b1;
        tick();
        rst = 1'b0;
        offer(32'h600, 5'd1, 32'd1, 5'd1, 32'd1, 3'd0, 5'd1, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (CMAX - 1) tick();
        chk("stall 0xFFFE", {16'd0, stall_cnt}, 32'h0000FFFE);
        tick();
        chk("stall 0xFFFF", {16'd0, stall_cnt}, 32'h0000FFFF);
        tick();
        chk("stall sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        rst = 1'b1;
        tick();
        chk("midrst valid", {31'd0, out_valid}, 32'd0);
        chk("midrst stall", {16'd0, stall_cnt}, 32'd0);
        chk("midrst flush", {16'd0, flush_cnt}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter CNT_W, 16, width of the stall and flush performance counters.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  decode offers an instruction.
REQ-006 in_ready  out  1  stage accepts the offered instruction this cycle.
REQ-007 in_pc  in  32  instruction PC.
REQ-008 in_rs1_idx, in_rs2_idx  in  5 each  source register indices.
REQ-009 in_rs1_val, in_rs2_val  in  32 each  register-file read data.
REQ-010 in_imm  in  32  sign-extended immediate.
REQ-011 in_use_imm  in  1  B operand = immediate instead of rs2.
REQ-012 in_alu_op  in  3  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 mul, 6 mulh, 7 reserved.
REQ-013 in_rd_idx  in  5; in_rd_we  in  1  destination index and write enable.
REQ-014 fwd_mem_valid  in  1; fwd_mem_rd  in  5; fwd_mem_data  in  32  MEM-stage bypass.
REQ-015 fwd_wb_valid  in  1; fwd_wb_rd  in  5; fwd_wb_data  in  32  WB-stage bypass.
REQ-016 flush  in  1  kill held and offered instruction.
REQ-017 out_ready  in  1  ALU/EX consumer accepts output.
REQ-018 out_valid  out  1  held instruction valid.
REQ-019 alu_a, alu_b  out  32 each  ALU operands A and B.
REQ-020 alu_op  out  3  ALU opcode.
REQ-021 out_pc  out  32; out_rs2_val  out  32 (forwarded rs2, for stores); out_rd_idx  out  5; out_rd_we  out  1.
REQ-022 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-023 Single-entry register; in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-024 Accept = in_valid && in_ready; on accept all payload SHALL be captured next edge, out_valid=1; latency 1 cycle.
REQ-025 Output drained (out_valid && out_ready) with no accept SHALL clear out_valid next edge; drain and accept in same cycle SHALL replace entry, out_valid stays 1 (full throughput).
REQ-026 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-027 Forwarding evaluated at capture per source operand: index 0 -> 0; else MEM match (fwd_mem_valid, fwd_mem_rd==idx) -> fwd_mem_data; else WB match -> fwd_wb_data; else register-file value. MEM has priority over WB.
REQ-028 alu_a = forwarded rs1; alu_b = in_use_imm ? in_imm : forwarded rs2; out_rs2_val = forwarded rs2 regardless of in_use_imm.
REQ-029 in_alu_op==7 SHALL be captured unchanged; out_rd_we SHALL be forced 0 for it.
REQ-030 in_rd_idx==0 SHALL capture out_rd_we=0.
REQ-031 flush SHALL clear out_valid next edge and block accept that cycle, overriding out_ready and in_valid; payload registers may keep stale values.
REQ-032 stall_cnt SHALL increment each cycle out_valid && !out_ready && !flush; flush_cnt SHALL increment each cycle flush && out_valid; both saturate at 2^CNT_W-1.

Reset
REQ-033 rst SHALL set out_valid=0, alu_a=alu_b=out_pc=out_rs2_val=0, alu_op=0, out_rd_idx=0, out_rd_we=0, stall_cnt=flush_cnt=0.
REQ-034 rst has priority over flush, accept and drain; in_ready SHALL be 0 while rst=1; an entry held at reset is discarded.

Verification
REQ-035 Reset then in_valid, rs1=3 val 5, rs2=4 val 7, op 0, out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_op=0.
REQ-036 rs1=5, fwd_mem rd5=0xAA, fwd_wb rd5=0xBB, rf val 0x11 -> alu_a=0xAA; with fwd_mem_valid=0 -> 0xBB; rs1=0 with both matching rd0 -> alu_a=0.
REQ-037 Entry held, out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs unchanged, stall_cnt=4; out_ready=1 then next instruction appears following cycle, no bubble on back-to-back.
REQ-038 flush asserted with valid entry and in_valid=1 -> next cycle out_valid=0, offered instruction not captured, flush_cnt=1.
REQ-039 in_use_imm=1, imm=0xFFFFFFFC, rs2 val 9 -> alu_b=0xFFFFFFFC, out_rs2_val=9; op 7 with rd_we=1 -> out_rd_we=0.
REQ-040 stall_cnt preloaded by 2^16-1 stall cycles then one more -> remains 0xFFFF; rst mid-stall -> out_valid=0, counters 0.
